// File: rtl/sdram_host_bridge.sv
// Request FIFO and one-at-a-time issue sequencer in front of sdram_controller.
// Optional `SDRAM_BRIDGE_STATS_EN adds completed-access counters stat_wr_cnt/stat_rd_cnt.
module sdram_host_bridge #(
    parameter int HADDR_WIDTH    = 24,
    parameter int FIFO_DEPTH     = 4,
    parameter int ACCEPT_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [HADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]            req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [15:0]            resp_data,
    output logic                   timeout_err,
    output logic [HADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]            wr_data,
    output logic                   wr_enable,
    output logic [HADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_enable,
    input  logic [15:0]            rd_data,
    input  logic                   rd_ready,
    input  logic                   busy
`ifdef SDRAM_BRIDGE_STATS_EN
    ,
    output logic [15:0]            stat_wr_cnt,
    output logic [15:0]            stat_rd_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] T_MAX    = TW'(ACCEPT_TIMEOUT);
    localparam logic [TW-1:0] T_LAST   = TW'(ACCEPT_TIMEOUT - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [HADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [15:0]            fifo_wdata [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_we;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic [1:0]    state;
    logic          cur_we;
    logic          rd_seen;
    logic [TW-1:0] tcnt;
    logic          push;
    logic          pop;
    logic          head_we;
    logic          done_exit;

    assign req_ready = (count != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign head_we   = fifo_we[rd_ptr];
    // A read waits at the head while an unclaimed response is pending.
    assign pop       = (state == IDLE) && (count != '0) && (head_we || !resp_valid);
    assign done_exit = (state == WAIT_DONE) && !busy && (cur_we || rd_seen);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
            fifo_we[wr_ptr]    <= req_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_we      <= 1'b0;
            rd_seen     <= 1'b0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
            wr_enable   <= 1'b0;
            rd_enable   <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_data     <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
        end else begin
            if (resp_valid && resp_ready)
                resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        wr_addr   <= fifo_addr[rd_ptr];
                        rd_addr   <= fifo_addr[rd_ptr];
                        wr_data   <= fifo_wdata[rd_ptr];
                        cur_we    <= head_we;
                        wr_enable <= head_we;
                        rd_enable <= !head_we;
                        rd_seen   <= 1'b0;
                        tcnt      <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (busy) begin
                        wr_enable <= 1'b0;
                        rd_enable <= 1'b0;
                        state     <= WAIT_DONE;
                    end else begin
                        // Keep waiting (no abort); only flag a stalled controller.
                        if (tcnt != T_MAX)
                            tcnt <= tcnt + TW'(1);
                        if (tcnt >= T_LAST)
                            timeout_err <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!cur_we && rd_ready) begin
                        resp_data  <= rd_data;
                        resp_valid <= 1'b1;
                        rd_seen    <= 1'b1;
                    end
                    if (done_exit)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_BRIDGE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else if (done_exit) begin
            if (cur_we)
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            else
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_host_bridge.sv
// Directed bench for sdram_host_bridge with a simple busy/rd_ready controller model.
// Stats checks compile only when SDRAM_BRIDGE_STATS_EN is defined.
module tb_sdram_host_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        timeout_err;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_enable;
    logic [23:0] rd_addr;
    logic        rd_enable;
    logic [15:0] rd_data  = 16'h0;
    logic        rd_ready = 1'b0;
    logic        busy     = 1'b0;
`ifdef SDRAM_BRIDGE_STATS_EN
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;
`endif

    sdram_host_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .timeout_err(timeout_err),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data),
        .rd_ready(rd_ready), .busy(busy)
`ifdef SDRAM_BRIDGE_STATS_EN
        ,
        .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int both_cnt = 0;
    int wr_issue_cnt = 0;
    int rd_issue_cnt = 0;
    logic m_ignore = 1'b0;

    // Controller model: accepts an enable from idle, raises busy 2 cycles after
    // the enable, writes finish a few cycles later, reads pulse rd_ready 7 cycles after busy.
    logic [15:0] mmem [16] = '{5: 16'h5A5A, default: 16'h0000};
    int          m_state = 0;
    int          m_cnt = 0;
    logic        m_read = 1'b0;
    logic [23:0] m_addr = 24'h0;
    logic [15:0] m_wdata = 16'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_ready <= 1'b0;
        case (m_state)
            0: if (!m_ignore && (wr_enable || rd_enable)) begin
                m_state <= 1;
                m_read  <= rd_enable;
                m_addr  <= rd_enable ? rd_addr : wr_addr;
                m_wdata <= wr_data;
                if (rd_enable) rd_issue_cnt <= rd_issue_cnt + 1;
                else           wr_issue_cnt <= wr_issue_cnt + 1;
            end
            1: begin
                busy    <= 1'b1;
                m_cnt   <= 0;
                m_state <= 2;
            end
            default: begin
                m_cnt <= m_cnt + 1;
                if (m_read) begin
                    if (m_cnt == 6) begin
                        rd_ready <= 1'b1;
                        rd_data  <= mmem[m_addr[3:0]];
                    end
                    if (m_cnt == 7) begin
                        busy    <= 1'b0;
                        m_state <= 0;
                    end
                end else if (m_cnt == 3) begin
                    mmem[m_addr[3:0]] <= m_wdata;
                    busy    <= 1'b0;
                    m_state <= 0;
                end
            end
        endcase
    end

    always @(negedge clk)
        if (wr_enable && rd_enable) both_cnt <= both_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Called at a negedge; the request is taken at the following posedge.
    task automatic applyStimulus(input logic we, input logic [23:0] addr, input logic [15:0] data);
        int n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n == 300) checkOutput("push_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitResp(input string tag, input int maxc);
        int n = 0;
        while (!resp_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic waitBusy(input string tag, input logic lvl, input int maxc);
        int n = 0;
        while (busy !== lvl && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, busy}, {31'b0, lvl});
    endtask

    task automatic waitWrEn(input string tag, input int maxc);
        int n = 0;
        while (!wr_enable && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, wr_enable}, 32'd1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int wb, rb, start;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_wr_enable", {31'b0, wr_enable}, 32'd0);
        checkOutput("rst_rd_enable", {31'b0, rd_enable}, 32'd0);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_timeout", {31'b0, timeout_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] write then read back");
        wb = wr_issue_cnt; rb = rd_issue_cnt;
        applyStimulus(1'b1, 24'h001234, 16'hBEEF);
        applyStimulus(1'b0, 24'h001234, 16'h0000);
        checkOutput("t1_wr_enable", {31'b0, wr_enable}, 32'd1);
        checkOutput("t1_wr_addr", {8'b0, wr_addr}, 32'h001234);
        checkOutput("t1_wr_data", {16'b0, wr_data}, 32'hBEEF);
        waitResp("t1_resp_valid", 100);
        checkOutput("t1_resp_data", {16'b0, resp_data}, 32'hBEEF);
        checkOutput("t1_wr_issues", wr_issue_cnt - wb, 32'd1);
        checkOutput("t1_rd_issues", rd_issue_cnt - rb, 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("t1_resp_clear", {31'b0, resp_valid}, 32'd0);
        repeat (5) @(negedge clk);

        $display("[TB] response backpressure");
        wb = wr_issue_cnt; rb = rd_issue_cnt;
        applyStimulus(1'b0, 24'h000005, 16'h0000);
        applyStimulus(1'b1, 24'h000006, 16'h1111);
        applyStimulus(1'b0, 24'h000006, 16'h0000);
        waitResp("t3_resp1_valid", 100);
        checkOutput("t3_resp1_data", {16'b0, resp_data}, 32'h5A5A);
        repeat (60) @(negedge clk);
        checkOutput("t3_write_issued", wr_issue_cnt - wb, 32'd1);
        checkOutput("t3_read2_held", rd_issue_cnt - rb, 32'd1);
        checkOutput("t3_resp_held", {31'b0, resp_valid}, 32'd1);
        checkOutput("t3_resp_data_held", {16'b0, resp_data}, 32'h5A5A);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        waitResp("t3_resp2_valid", 100);
        checkOutput("t3_resp2_data", {16'b0, resp_data}, 32'h1111);
        checkOutput("t3_rd_issues", rd_issue_cnt - rb, 32'd2);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] reset during read");
        rb = rd_issue_cnt;
        applyStimulus(1'b0, 24'h000004, 16'h0000);
        waitBusy("t4_busy", 1'b1, 50);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t4_rd_enable", {31'b0, rd_enable}, 32'd0);
        checkOutput("t4_wr_enable", {31'b0, wr_enable}, 32'd0);
        checkOutput("t4_rd_addr", {8'b0, rd_addr}, 32'd0);
        checkOutput("t4_wr_data", {16'b0, wr_data}, 32'd0);
        checkOutput("t4_resp_data", {16'b0, resp_data}, 32'd0);
        checkOutput("t4_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t4_late_rd_ready", {31'b0, resp_valid}, 32'd0);
        checkOutput("t4_no_reissue", rd_issue_cnt - rb, 32'd1);

        $display("[TB] stalled controller and full FIFO");
        m_ignore = 1'b1;
        applyStimulus(1'b1, 24'h000100, 16'hA0A0);
        waitWrEn("t2_enable", 20);
        start = cyc;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 24'h000101 + 24'(i), 16'h0);
        checkOutput("t2_full_ready", {31'b0, req_ready}, 32'd0);
        while (cyc < start + 254) @(negedge clk);
        checkOutput("t2_timeout_early", {31'b0, timeout_err}, 32'd0);
        @(negedge clk);
        checkOutput("t2_timeout_set", {31'b0, timeout_err}, 32'd1);
        checkOutput("t2_enable_held", {31'b0, wr_enable}, 32'd1);
        doReset();
        m_ignore = 1'b0;
        checkOutput("t2_timeout_rst", {31'b0, timeout_err}, 32'd0);

        $display("[TB] push and pop at count 3");
        wb = wr_issue_cnt;
        m_ignore = 1'b1;
        applyStimulus(1'b1, 24'h000028, 16'h0028);
        waitWrEn("t5_enable", 20);
        applyStimulus(1'b1, 24'h000029, 16'h0029);
        applyStimulus(1'b1, 24'h00002A, 16'h002A);
        applyStimulus(1'b1, 24'h00002B, 16'h002B);
        checkOutput("t5_cnt3_ready", {31'b0, req_ready}, 32'd1);
        m_ignore = 1'b0;
        waitBusy("t5_busy_hi", 1'b1, 20);
        waitBusy("t5_busy_lo", 1'b0, 50);
        @(negedge clk);
        applyStimulus(1'b1, 24'h00002C, 16'h002C);
        checkOutput("t5_pop_same_cycle", {31'b0, wr_enable}, 32'd1);
        checkOutput("t5_count_hold", {31'b0, req_ready}, 32'd1);
        applyStimulus(1'b1, 24'h00002D, 16'h002D);
        checkOutput("t5_full", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h00002E; req_wdata = 16'h002E;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("t5_still_full", {31'b0, req_ready}, 32'd0);
        repeat (150) @(negedge clk);
        checkOutput("t5_writes_issued", wr_issue_cnt - wb, 32'd6);
        checkOutput("t5_last_write", {16'b0, mmem[13]}, 32'h002D);
        checkOutput("t5_rejected_write", {16'b0, mmem[14]}, 32'h0000);

`ifdef SDRAM_BRIDGE_STATS_EN
        $display("[TB] statistics counters");
        doReset();
        checkOutput("st_wr_rst", {16'b0, stat_wr_cnt}, 32'd0);
        resp_ready = 1'b1;
        applyStimulus(1'b1, 24'h000001, 16'h0101);
        applyStimulus(1'b0, 24'h000001, 16'h0000);
        applyStimulus(1'b1, 24'h000002, 16'h0202);
        applyStimulus(1'b0, 24'h000002, 16'h0000);
        applyStimulus(1'b1, 24'h000003, 16'h0303);
        repeat (150) @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("st_wr_cnt", {16'b0, stat_wr_cnt}, 32'd3);
        checkOutput("st_rd_cnt", {16'b0, stat_rd_cnt}, 32'd2);
`endif

        checkOutput("excl_enables", both_cnt, 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
